// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC time-pulse generator.
//   agc_state_e : sequencer state (IDLE, RUN, STEP, ACK)
//   AGC_TICKS_PER_T / AGC_NUM_T : default tick and pulse counts
//   agc_idx_w() : width of an index that selects one of n one-hot positions
package agc_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    ACK  = 2'd3
  } agc_state_e;

  localparam int AGC_TICKS_PER_T = 4;
  localparam int AGC_NUM_T       = 12;

  // Never narrower than one bit, so n=1 or n=2 still gets a usable counter.
  function automatic int agc_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/agc_tp_counter.sv
// Nested tick / time-pulse index counter.
//   clk, rst : clock, async active-low reset
//   clr      : synchronous clear to tick=0, tidx=0 (wins over en)
//   en       : advance one tick
//   tick     : position inside the current time pulse
//   tidx     : current time pulse (0 = T01)
//   eoc      : last tick of the last pulse (end of memory cycle)
module agc_tp_counter
  import agc_timing_pkg::*;
#(
  parameter int TICKS_PER_T = AGC_TICKS_PER_T,
  parameter int NUM_T       = AGC_NUM_T,
  parameter int TW          = agc_idx_w(TICKS_PER_T),
  parameter int IW          = agc_idx_w(NUM_T)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [TW-1:0] tick,
  output logic [IW-1:0] tidx,
  output logic          eoc
);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_T - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_T - 1);

  logic tick_wrap;
  assign tick_wrap = (tick == TICK_LAST);
  assign eoc       = tick_wrap && (tidx == IDX_LAST);

  // Both counters wrap explicitly at their last legal value, so neither
  // can hold an out-of-range code even when NUM_T is not a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick <= '0;
      tidx <= '0;
    end else if (clr) begin
      tick <= '0;
      tidx <= '0;
    end else if (en) begin
      if (tick_wrap) begin
        tick <= '0;
        tidx <= (tidx == IDX_LAST) ? '0 : tidx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC memory-cycle time-pulse generator.
//   clk, rst : master clock, async active-low reset
//   run      : level, free-run memory cycles (sampled only at cycle end)
//   step_req : level, request one memory cycle while stopped
//   step_ack : one-cycle pulse after a stepped cycle completes
//   t_pulse  : one-hot T01..T12 (bit 0 = T01), zero when stopped
//   phi1/phi2: first/second half of each time pulse, never both high
//   mct      : one-cycle pulse on the last tick of T12
//   running  : high whenever t_pulse is non-zero
module agc_timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int TICKS_PER_T = AGC_TICKS_PER_T,
  parameter int NUM_T       = AGC_NUM_T
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_req,
  output logic             step_ack,
  output logic [NUM_T-1:0] t_pulse,
  output logic             phi1,
  output logic             phi2,
  output logic             mct,
  output logic             running
);

  localparam int TW = agc_idx_w(TICKS_PER_T);
  localparam int IW = agc_idx_w(NUM_T);
  localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_T / 2);

  agc_state_e    state;
  logic [TW-1:0] tick;
  logic [IW-1:0] tidx;
  logic          eoc;
  logic          active;

  assign active = (state == RUN) || (state == STEP);

  // Counters sit at zero while stopped, so entering RUN/STEP shows T01
  // on the very next cycle; in RUN the counter's own wrap gives the
  // gapless T12 -> T01 hand-off.
  agc_tp_counter #(
    .TICKS_PER_T (TICKS_PER_T),
    .NUM_T       (NUM_T),
    .TW          (TW),
    .IW          (IW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!active),
    .en   (active),
    .tick (tick),
    .tidx (tidx),
    .eoc  (eoc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run)           state <= RUN;
          else if (step_req) state <= STEP;
        end
        RUN:  if (eoc && !run) state <= IDLE;
        STEP: if (eoc)         state <= ACK;
        ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so an async reset
  // clears them immediately with no partial pulse.
  assign t_pulse  = active ? (NUM_T'(1) << tidx) : '0;
  assign phi1     = active && (tick < TICK_HALF);
  assign phi2     = active && (tick >= TICK_HALF);
  assign mct      = active && eoc;
  assign running  = active;
  assign step_ack = (state == ACK);

endmodule

// File: tb/tb_agc_timepulse_gen.sv
module tb_agc_timepulse_gen;

  localparam int TPT  = 4;
  localparam int NT   = 12;
  localparam int LAST = TPT * NT - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          step_req = 1'b0;
  logic          step_ack;
  logic [NT-1:0] t_pulse;
  logic          phi1, phi2, mct, running;

  agc_timepulse_gen #(.TICKS_PER_T(TPT), .NUM_T(NT)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .step_req (step_req),
    .step_ack (step_ack),
    .t_pulse  (t_pulse),
    .phi1     (phi1),
    .phi2     (phi2),
    .mct      (mct),
    .running  (running)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: mode 0 stopped, 1 free-run, 2 single step, 3 ack;
  // pos is the clock count 0..LAST inside the current memory cycle.
  int m_mode = 0;
  int m_pos  = 0;
  int n_mct  = 0;
  int n_ack  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    case (m_mode)
      0: begin
        if (run)           begin m_mode = 1; m_pos = 0; end
        else if (step_req) begin m_mode = 2; m_pos = 0; end
      end
      1: begin
        if (m_pos == LAST) begin
          m_pos = 0;
          if (!run) m_mode = 0;
        end else m_pos++;
      end
      2: begin
        if (m_pos == LAST) begin m_mode = 3; m_pos = 0; end
        else m_pos++;
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic cmp_all(input string tag);
    logic        act;
    logic [31:0] e_tp;
    logic        e_p1;
    act  = (m_mode == 1) || (m_mode == 2);
    e_tp = act ? (32'd1 << (m_pos / TPT)) : 32'd0;
    e_p1 = act && ((m_pos % TPT) < TPT / 2);
    chk({tag, "_tp"}, 32'(t_pulse), e_tp);
    chk({tag, "_fl"}, {27'd0, phi1, phi2, mct, running, step_ack},
        {27'd0, e_p1, act && !e_p1, act && (m_pos == LAST), act, (m_mode == 3)});
    n_mct += int'(mct);
    n_ack += int'(step_ack);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    cmp_all(tag);
  endtask

  initial begin
    int n;

    // reset held 3 cycles
    repeat (3) cyc("rst");
    rst = 1'b1;
    cyc("idle");

    // run: T01 one cycle later, T02 after 4 more, mct at cycle 48
    run = 1'b1;
    cyc("run");
    chk("t01", 32'(t_pulse), 32'h001);
    repeat (4) cyc("run");
    chk("t02", 32'(t_pulse), 32'h002);
    repeat (43) cyc("run");
    chk("mct48", 32'(mct), 32'd1);

    // drop run during T05: cycle must complete, then stop
    n = 0;
    while (m_pos / TPT != 4 && n < 200) begin cyc("to5"); n++; end
    chk("reach_t05", m_pos / TPT, 4);
    run = 1'b0;
    n_mct = 0;
    n = 0;
    while (m_mode != 0 && n < 200) begin cyc("stop"); n++; end
    chk("stop_mct", n_mct, 1);
    chk("stop_run", 32'(running), 32'(m_mode != 0));
    repeat (3) cyc("stopped");

    // single step: one full cycle, one mct, one ack
    n_mct = 0;
    n_ack = 0;
    step_req = 1'b1;
    cyc("step");
    step_req = 1'b0;
    repeat (55) cyc("step");
    chk("step_mct", n_mct, 1);
    chk("step_ack", n_ack, 1);

    // step_req while running is ignored
    run = 1'b1;
    cyc("run2");
    n_ack = 0;
    repeat (150) begin
      step_req = 1'($urandom_range(0, 1));
      cyc("ign");
    end
    step_req = 1'b0;
    chk("ign_ack", n_ack, 0);

    // async reset at T07 tick 2, between edges
    n = 0;
    while (!(m_mode == 1 && m_pos == 25) && n < 200) begin cyc("to7"); n++; end
    chk("reach_t07", m_pos, 25);
    @(posedge clk);
    model_step();
    #2 rst = 1'b0;
    #1;
    chk("arst_tp", 32'(t_pulse), 32'd0);
    chk("arst_fl", {27'd0, phi1, phi2, mct, running, step_ack}, 32'd0);
    m_mode = 0;
    m_pos  = 0;
    @(negedge clk);
    cmp_all("arst");
    rst = 1'b1;
    run = 1'b1;
    cyc("rest");
    chk("rest_t01", 32'(t_pulse), 32'h001);

    // random run/step activity
    repeat (1000) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 7) == 0)  step_req = ~step_req;
      cyc("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
